adder_4bit: RTL and testbench

- 4-bit binary adder with carry-in/carry-out, built as a ripple chain of full-adder cells.
- Provides a zero-latency combinational sum path plus a one-cycle registered copy of the result with a valid flag.
- Used as the arithmetic leaf in datapath exercises. Benches may drive it purely combinationally, with clk idle.

---
 rtl/adder_4bit.sv | 77 +++++++
 tb/tb_adder_4bit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/adder_4bit.sv
// Ripple-carry adder with a combinational sum and a one-cycle registered copy.
// Define ADDER_STATUS_EN to add registered zero/signed-overflow flags.
module adder_4bit #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    input  logic             c_in,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic [WIDTH:0]   sum_q,
    output logic             valid_q
`ifdef ADDER_STATUS_EN
    ,
    output logic             zero_q,
    output logic             ovf_q
`endif
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   r_sum;
    logic             r_valid;

    assign w_carry[0] = c_in;

    // One full-adder cell per bit; carry of bit gi feeds bit gi+1.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
            logic w_p;
            assign w_p            = x[gi] ^ y[gi];
            assign w_sum[gi]      = w_p ^ w_carry[gi];
            assign w_carry[gi+1]  = (x[gi] & y[gi]) | (w_carry[gi] & w_p);
        end
    endgenerate

    assign s     = w_sum;
    assign c_out = w_carry[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum <= {w_carry[WIDTH], w_sum};
            end
        end
    end

    assign sum_q   = r_sum;
    assign valid_q = r_valid;

`ifdef ADDER_STATUS_EN
    logic r_zero;
    logic r_ovf;

    // Zero looks only at the WIDTH-bit sum; overflow is carry-in vs carry-out of the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (in_valid) begin
            r_zero <= (w_sum == '0);
            r_ovf  <= w_carry[WIDTH-1] ^ w_carry[WIDTH];
        end
    end

    assign zero_q = r_zero;
    assign ovf_q  = r_ovf;
`endif

endmodule

// File: tb/tb_adder_4bit.sv
// Directed self-checking bench for adder_4bit: combinational vectors, registered
// pipeline, hold behaviour and mid-stream reset.
module tb_adder_4bit;

    logic [3:0] s;
    logic       c_out;
    logic       c_in;
    logic [3:0] x;
    logic [3:0] y;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [4:0] sum_q;
    logic       valid_q;
`ifdef ADDER_STATUS_EN
    logic       zero_q;
    logic       ovf_q;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    adder_4bit #(.WIDTH(4)) dut (
        .s        (s),
        .c_out    (c_out),
        .c_in     (c_in),
        .x        (x),
        .y        (y),
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .sum_q    (sum_q),
        .valid_q  (valid_q)
`ifdef ADDER_STATUS_EN
        ,
        .zero_q   (zero_q),
        .ovf_q    (ovf_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; x = 4'd0; y = 4'd0; c_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (sum_q !== 5'd0 || valid_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: sum_q=%b valid_q=%b, expected 00000/0", sum_q, valid_q);
        end else
            $display("[TB] reset: sum_q=%b valid_q=%b", sum_q, valid_q);
        rst = 1'b0;
    endtask

    task automatic test_comb();
        logic [3:0] vx [8] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd10, 4'd15, 4'd15, 4'd7};
        logic [3:0] vy [8] = '{4'd0, 4'd1, 4'd0, 4'd3, 4'd15, 4'd15, 4'd15, 4'd8};
        logic       vc [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  1'b0,  1'b1,  1'b1};
        logic [4:0] ve [8] = '{5'b0_0000, 5'b0_0001, 5'b0_0001, 5'b0_0101,
                               5'b1_1010, 5'b1_1110, 5'b1_1111, 5'b1_0000};
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = vx[i]; y = vy[i]; c_in = vc[i];
            #1;
            tests_run++;
            if ({c_out, s} !== ve[i]) begin
                tests_failed++;
                $display("FAIL comb[%0d]: x=%0d y=%0d c_in=%b got %b, expected %b",
                         i, vx[i], vy[i], vc[i], {c_out, s}, ve[i]);
            end else
                $display("[TB] comb[%0d]: x=%0d y=%0d c_in=%b -> %b", i, vx[i], vy[i], vc[i], {c_out, s});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vx [3] = '{4'd2, 4'd10, 4'd15};
        logic [3:0] vy [3] = '{4'd3, 4'd15, 4'd15};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [4:0] ve [3] = '{5'b0_0101, 5'b1_1010, 5'b1_1111};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            x = vx[i]; y = vy[i]; c_in = vc[i]; in_valid = 1'b1;
            @(negedge clk);
            tests_run++;
            if (sum_q !== ve[i] || valid_q !== 1'b1) begin
                tests_failed++;
                $display("FAIL pipe[%0d]: sum_q=%b valid_q=%b, expected %b/1", i, sum_q, valid_q, ve[i]);
            end else
                $display("[TB] pipe[%0d]: sum_q=%b valid_q=%b", i, sum_q, valid_q);
        end
        in_valid = 1'b0; x = 4'd1; y = 4'd1; c_in = 1'b0;
        repeat (2) begin
            @(negedge clk);
            tests_run++;
            if (sum_q !== 5'b1_1111 || valid_q !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold: sum_q=%b valid_q=%b, expected 11111/0", sum_q, valid_q);
            end else
                $display("[TB] hold: sum_q=%b valid_q=%b", sum_q, valid_q);
        end
    endtask

`ifdef ADDER_STATUS_EN
    task automatic test_status();
        logic [3:0] vx [3] = '{4'd0, 4'd7, 4'd8};
        logic [3:0] vy [3] = '{4'd0, 4'd1, 4'd8};
        logic       ez [3] = '{1'b1, 1'b0, 1'b1};
        logic       eo [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            x = vx[i]; y = vy[i]; c_in = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            tests_run++;
            if (zero_q !== ez[i] || ovf_q !== eo[i]) begin
                tests_failed++;
                $display("FAIL status[%0d]: zero_q=%b ovf_q=%b, expected %b/%b", i, zero_q, ovf_q, ez[i], eo[i]);
            end else
                $display("[TB] status[%0d]: zero_q=%b ovf_q=%b", i, zero_q, ovf_q);
        end
        in_valid = 1'b1; x = 4'd15; y = 4'd15; c_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_midstream();
        rst = 1'b1; in_valid = 1'b1; x = 4'd15; y = 4'd15; c_in = 1'b0;
        #1;
        tests_run++;
        if ({c_out, s} !== 5'b1_1110) begin
            tests_failed++;
            $display("FAIL comb_in_reset: got %b, expected 11110", {c_out, s});
        end else
            $display("[TB] comb_in_reset: %b", {c_out, s});
        @(negedge clk);
        tests_run++;
        if (sum_q !== 5'd0 || valid_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: sum_q=%b valid_q=%b, expected 00000/0", sum_q, valid_q);
        end else
            $display("[TB] mid_reset: sum_q=%b valid_q=%b", sum_q, valid_q);
`ifdef ADDER_STATUS_EN
        tests_run++;
        if (zero_q !== 1'b0 || ovf_q !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_status: zero_q=%b ovf_q=%b, expected 0/0", zero_q, ovf_q);
        end else
            $display("[TB] mid_reset_status: zero_q=%b ovf_q=%b", zero_q, ovf_q);
`endif
        rst = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb();
        test_back_to_back();
`ifdef ADDER_STATUS_EN
        test_status();
`endif
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
